pc_sequencer: RTL and testbench

- Controller that owns and sequences the MIPS program counter.
- Selects the next PC from sequential increment, branch redirect or jump redirect.
- Holds the PC on pipeline stalls and on instruction-memory back-pressure.
- Sits between the hazard/branch logic and the instruction-fetch port, replacing the free-running PC latch.

---
 rtl/pc_sequencer.sv | 92 +++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// MIPS program-counter sequencer: boot delay, sequential/branch/jump next-PC
// selection, and hold on hazard stall or instruction-memory back-pressure.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BOOT_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic        flush,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  BOOT_LAST = 4'(BOOT_DELAY - 1);
    localparam logic [31:0] ALIGN     = 32'hFFFF_FFFC;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        flush_nxt;

    // Once in WAIT the request is committed; stall can no longer retract it.
    assign imem_req    = (state == RUN && !stall) || state == WAIT;
    assign fetch_valid = imem_req & imem_ready;
    assign state_o     = state;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        flush_nxt = 1'b0;
        case (state)
            BOOT: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == BOOT_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end
            end
            RUN, WAIT: begin
                // Redirects win over stall and abandon any pending request.
                if (br_taken) begin
                    pc_nxt    = $isunknown(br_target) ? RESET_PC : (br_target & ALIGN);
                    state_nxt = RUN;
                    flush_nxt = 1'b1;
                end else if (jmp) begin
                    pc_nxt    = $isunknown(jmp_target) ? RESET_PC : (jmp_target & ALIGN);
                    state_nxt = RUN;
                    flush_nxt = 1'b1;
                end else if (state == WAIT) begin
                    if (imem_ready) begin
                        pc_nxt    = pc + 32'd4;
                        state_nxt = RUN;
                    end
                end else if (!stall) begin
                    if (imem_ready) pc_nxt = pc + 32'd4;
                    else            state_nxt = WAIT;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
            cnt   <= 4'd0;
            flush <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            flush <= flush_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, back-pressure, redirect priority,
// stall, wrap-around and asynchronous reset while a request is pending.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        imem_ready;
    logic [31:0] pc;
    logic        imem_req;
    logic        fetch_valid;
    logic        flush;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .BOOT_DELAY(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target), .imem_ready(imem_ready),
        .pc(pc), .imem_req(imem_req), .fetch_valid(fetch_valid),
        .flush(flush), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
        br_target = 32'h0; jmp_target = 32'h0; imem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    endtask

    task automatic test_boot_seq();
        rst_n = 1'b1;
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL boot1_state got %0d exp 0", state_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot1_req got %b exp 0", imem_req); end
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL boot2_state got %0d exp 1", state_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot2_req got %b exp 1", imem_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot2_pc got %h exp 0", pc); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL boot2_fv got %b exp 1", fetch_valid); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc4 got %h exp 4", pc); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv4 got %b exp 1", fetch_valid); end
        tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc8 got %h exp 8", pc); end
        tick(); tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_pc10 got %h exp 10", pc); end
    endtask

    task automatic test_backpressure();
        imem_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1;
            #1;
            checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL wait_state[%0d] got %0d exp 2", i, state_o); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d] got %b exp 1", i, imem_req); end
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL wait_pc[%0d] got %h exp 10", i, pc); end
            if (i == 0) tick();
        end
        imem_ready = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL wait_fv got %b exp 1", fetch_valid); end
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL wait_done_pc got %h exp 14", pc); end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL wait_done_state got %0d exp 1", state_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL run_stall_req got %b exp 0", imem_req); end
        stall = 1'b0;
    endtask

    task automatic test_redirect_priority();
        jmp = 1'b1; jmp_target = 32'h0000_001C;
        tick();
        jmp = 1'b0;
        checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL jmp_pc got %h exp 1c", pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp_flush got %b exp 1", flush); end
        tick();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL pre_br_pc got %h exp 20", pc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", flush); end
        br_taken = 1'b1; jmp = 1'b1; stall = 1'b1;
        br_target = 32'h0000_0103; jmp_target = 32'h0000_0200;
        tick();
        br_taken = 1'b0; jmp = 1'b0; stall = 1'b0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got %h exp 100", pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", flush); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_once got %b exp 0", flush); end
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL br_next_pc got %h exp 104", pc); end
    endtask

    task automatic test_back_to_back();
        jmp = 1'b1; jmp_target = 32'h0000_003C;
        tick();
        jmp = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0040;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush1 got %b exp 1", flush); end
        tick();
        br_taken = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush2 got %b exp 1", flush); end
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL b2b_pc got %h exp 40", pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, imem_req); end
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv[%0d] got %b exp 0", i, fetch_valid); end
            tick();
            checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 40", i, pc); end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL unstall_req got %b exp 1", imem_req); end
        tick();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL unstall_pc got %h exp 44", pc); end
    endtask

    task automatic test_wrap();
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick();
        jmp = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jmp_pc got %h exp fffffffc", pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL wrap_flush got %b exp 1", flush); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL wrap_flush_drop got %b exp 0", flush); end
    endtask

    task automatic test_async_reset();
        jmp = 1'b1; jmp_target = 32'h0000_0080; imem_ready = 1'b0;
        tick();
        jmp = 1'b0;
        tick();
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL pre_rst_state got %0d exp 2", state_o); end
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL pre_rst_pc got %h exp 80", pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h exp 0", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req got %b exp 0", imem_req); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL async_rst_state got %0d exp 0", state_o); end
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reboot1_req got %b exp 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reboot2_req got %b exp 1", imem_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reboot2_pc got %h exp 0", pc); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL reboot3_pc got %h exp 4", pc); end
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_backpressure();
        test_redirect_priority();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
